// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants and frame type shared by the 7-segment capture blocks.
package seg7_pkg;

    // Segment patterns, bit order g..a, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam int         SEG_DOT_BIT = 7;

    typedef logic [3:0][3:0] seg7_frame_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// seg7_scan_capture_if: multiplexed display bus in, reconstructed frame and status out.
interface seg7_scan_capture_if;
    import seg7_pkg::*;

    logic [7:0]  i_Segments;
    logic [3:0]  i_Digits;
    seg7_frame_t o_Frame;
    logic [3:0]  o_Dots;
    logic        o_Frame_Valid;
    logic        o_Blank;
    logic        o_Pattern_Err;
    logic [7:0]  o_Err_Count;

    modport master (
        output i_Segments, i_Digits,
        input  o_Frame, o_Dots, o_Frame_Valid, o_Blank, o_Pattern_Err, o_Err_Count
    );

    modport slave (
        input  i_Segments, i_Digits,
        output o_Frame, o_Dots, o_Frame_Valid, o_Blank, o_Pattern_Err, o_Err_Count
    );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 7-bit segment pattern to BCD digit, flagging blank and invalid patterns.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_Pattern,
    output logic       o_Valid,
    output logic       o_Is_Blank,
    output logic [3:0] o_Bcd
);

    always_comb begin
        o_Valid    = 1'b1;
        o_Is_Blank = 1'b0;
        o_Bcd      = BCD_BLANK;
        case (i_Pattern)
            SEG_0:     o_Bcd = 4'd0;
            SEG_1:     o_Bcd = 4'd1;
            SEG_2:     o_Bcd = 4'd2;
            SEG_3:     o_Bcd = 4'd3;
            SEG_4:     o_Bcd = 4'd4;
            SEG_5:     o_Bcd = 4'd5;
            SEG_6:     o_Bcd = 4'd6;
            SEG_7:     o_Bcd = 4'd7;
            SEG_8:     o_Bcd = 4'd8;
            SEG_9:     o_Bcd = 4'd9;
            SEG_BLANK: o_Is_Blank = 1'b1;
            default:   o_Valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a multiplexed 7-segment bus and rebuilds the displayed 4-digit frame.
// Define SEG_CAPTURE_ERR_COUNT_EN to build the saturating pattern-error counter.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_FRAMES = 2,
    parameter int BLANK_TIMEOUT = 1024
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    seg7_scan_capture_if.slave bus
);

    localparam int              BW          = $clog2(BLANK_TIMEOUT + 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      MATCH_MAX   = 4'(STABLE_FRAMES);
    localparam logic [BW-1:0]   BLANK_MAX   = BW'(BLANK_TIMEOUT);

    logic [7:0]    r_seg_p0, r_seg_p1;
    logic [3:0]    r_dig_p0, r_dig_p1;
    logic [7:0]    r_settle;
    logic [BW-1:0] r_blank_cnt;
    logic [3:0]    r_seen, r_match;
    seg7_frame_t   r_slots, r_prev, r_frame;
    logic [3:0]    r_slot_dots, r_prev_dots, r_dots;
    logic          r_vld_p1, r_frame_valid, r_perr;

    logic          w_dec_valid, w_dec_blank;
    logic [3:0]    w_dec_bcd, w_bcd;
    logic          w_changed, w_accept, w_good, w_complete, w_same, w_blank;
    seg7_frame_t   w_slots_nxt;
    logic [3:0]    w_dots_nxt, w_seen_nxt, w_match_nxt;

    seg7_decode u_decode (
        .i_Pattern  (r_seg_p0[6:0]),
        .o_Valid    (w_dec_valid),
        .o_Is_Blank (w_dec_blank),
        .o_Bcd      (w_dec_bcd)
    );

    always_comb begin
        w_bcd       = w_dec_blank ? BCD_BLANK : w_dec_bcd;
        w_changed   = (r_seg_p0 != r_seg_p1) || (r_dig_p0 != r_dig_p1);
        // One accept per dwell: the settle counter passes SETTLE_LAST exactly once before saturating
        w_accept    = !w_changed && (r_settle == SETTLE_LAST) && (r_dig_p0 != 4'd0);
        w_good      = w_accept && w_dec_valid;
        w_slots_nxt = r_slots;
        w_dots_nxt  = r_slot_dots;
        for (int i = 0; i < 4; i++) begin
            if (w_good && r_dig_p0[i]) begin
                w_slots_nxt[i] = w_bcd;
                w_dots_nxt[i]  = r_seg_p0[SEG_DOT_BIT];
            end
        end
        w_seen_nxt  = r_seen | (w_good ? r_dig_p0 : 4'd0);
        w_complete  = w_good && (w_seen_nxt == 4'b1111);
        w_same      = (w_slots_nxt == r_prev) && (w_dots_nxt == r_prev_dots);
        if (!w_same)
            w_match_nxt = 4'd1;
        else if (r_match >= MATCH_MAX)
            w_match_nxt = r_match;
        else
            w_match_nxt = r_match + 4'd1;
        w_blank     = (r_blank_cnt >= BLANK_MAX);
    end

    always_ff @(posedge i_Clock) begin
        // Stage p0/p1: input register and one-cycle history for change detection
        r_seg_p0 <= bus.i_Segments;
        r_dig_p0 <= bus.i_Digits;
        r_seg_p1 <= r_seg_p0;
        r_dig_p1 <= r_dig_p0;
        if (!i_Reset_n) begin
            r_settle      <= 8'd0;
            r_blank_cnt   <= '0;
            r_seen        <= 4'd0;
            r_match       <= 4'd0;
            r_slots       <= {4{BCD_BLANK}};
            r_prev        <= {4{BCD_BLANK}};
            r_slot_dots   <= 4'd0;
            r_prev_dots   <= 4'd0;
            r_vld_p1      <= 1'b0;
            r_frame       <= {4{BCD_BLANK}};
            r_dots        <= 4'd0;
            r_frame_valid <= 1'b0;
            r_perr        <= 1'b0;
        end else begin
            r_settle <= w_changed ? 8'd0 : ((r_settle == 8'hFF) ? r_settle : r_settle + 8'd1);
            if (r_dig_p0 != 4'd0)
                r_blank_cnt <= '0;
            else if (!w_blank)
                r_blank_cnt <= r_blank_cnt + BW'(1);
            r_perr      <= w_accept && !w_dec_valid;
            r_slots     <= w_slots_nxt;
            r_slot_dots <= w_dots_nxt;
            r_vld_p1    <= 1'b0;
            if (w_blank) begin
                r_seen  <= 4'd0;
                r_match <= 4'd0;
            end else if (w_complete) begin
                r_seen  <= 4'd0;
                r_match <= w_match_nxt;
                if (!w_same) begin
                    r_prev      <= w_slots_nxt;
                    r_prev_dots <= w_dots_nxt;
                end
                // A changed frame that stabilises immediately (STABLE_FRAMES==1) must still fire
                r_vld_p1 <= (w_match_nxt == MATCH_MAX) && (!w_same || (r_match != MATCH_MAX));
            end else begin
                r_seen <= w_seen_nxt;
            end
            // Stage p2: publish the stable frame
            r_frame_valid <= r_vld_p1;
            if (r_vld_p1) begin
                r_frame <= r_prev;
                r_dots  <= r_prev_dots;
            end
        end
    end

`ifdef SEG_CAPTURE_ERR_COUNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n)
            r_err_cnt <= 8'd0;
        else if (w_accept && !w_dec_valid && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign bus.o_Err_Count = r_err_cnt;
`else
    assign bus.o_Err_Count = 8'd0;
`endif

    assign bus.o_Frame       = r_frame;
    assign bus.o_Dots        = r_dots;
    assign bus.o_Frame_Valid = r_frame_valid;
    assign bus.o_Blank       = w_blank && (r_dig_p0 == 4'd0);
    assign bus.o_Pattern_Err = r_perr;

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the display mux driver: samples the multiplexed 7-segment bus (segments + digit enables) and reconstructs the displayed 4-digit value, dot bits and blank state.
- Used as an on-chip display readback/self-check block and as a checker inside clock_top-level benches.
- Emits a one-cycle pulse with the decoded frame once the same frame has been seen on consecutive scans.

Parameters:
- SETTLE_CYCLES, 4, cycles that segments/digits must be unchanged before a sample is accepted (1..255).
- STABLE_FRAMES, 2, identical consecutive complete frames required before o_Frame_Valid (1..15).
- BLANK_TIMEOUT, 1024, cycles of i_Digits==0 before o_Blank asserts (width = $clog2(BLANK_TIMEOUT+1)).

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  reset, synchronous, active-low.
- i_Segments  in  8  bit7 = dot, bits6:0 = g..a, active-high.
- i_Digits  in  4  digit enables, active-high; bit3 = leftmost (hours tens), bit0 = rightmost.
- o_Frame  out  16  BCD digits {d3,d2,d1,d0}; 4'hF = blank digit.
- o_Dots  out  4  dot bit per digit.
- o_Frame_Valid  out  1  one-cycle pulse: o_Frame/o_Dots updated.
- o_Blank  out  1  level: display dark for >= BLANK_TIMEOUT cycles.
- o_Pattern_Err  out  1  one-cycle pulse: accepted sample had an undecodable segment pattern.
- o_Err_Count  out  8  saturating error count (optional feature).

Behaviour:
- Reset (i_Reset_n==0 at posedge): o_Frame=16'hFFFF, o_Dots=0, o_Frame_Valid=0, o_Blank=0, o_Pattern_Err=0, o_Err_Count=0; seen mask, slots, match counter, settle and blank counters cleared. Reset mid-frame discards the partial frame.
- Stage 1: inputs registered once. Settle counter resets whenever the registered {segments,digits} differs from the previous cycle, otherwise increments, saturating.
- Accept event: exactly one per dwell, on the cycle the counter reaches SETTLE_CYCLES with i_Digits != 0. Dwells shorter than SETTLE_CYCLES are ignored (glitch/ghost rejection).
- Decode patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; 0000000 = blank (4'hF).
- Any other pattern: o_Pattern_Err pulses, the sample is not written, and the seen mask is unchanged.
- Valid accept: the decoded value and dot are written to every slot whose i_Digits bit is set (multi-hot writes all; 4'b1111 completes a frame in one accept), and those bits are OR-ed into the seen mask.
- Frame complete (seen mask == 4'b1111 after update): compare slots with the previous complete frame.
  - Equal: match count += 1, saturating at STABLE_FRAMES.
  - Not equal: match count = 1 and the previous frame is updated.
  - Seen mask cleared the same cycle.
- When match count reaches STABLE_FRAMES: o_Frame/o_Dots load and o_Frame_Valid pulses one cycle after frame complete. Frame Valid fires again only after a change followed by re-stabilisation; held frames do not repulse.
- Blank counter: increments while the registered i_Digits==0, clears otherwise. o_Blank=1 when count >= BLANK_TIMEOUT and drops on the first cycle with nonzero digits. A blank period also clears the seen mask and match count.
- Latency: input change to o_Frame_Valid = 1 (reg) + SETTLE_CYCLES + 1 for the completing accept, plus the frame repeats.
- Simultaneous pattern error and frame complete cannot occur, because an error does not update the mask.

Optional Feature:
- SEG_CAPTURE_ERR_COUNT_EN defined: o_Err_Count increments on each o_Pattern_Err, saturates at 255, and clears only on reset.
- Undefined: o_Err_Count tied to 8'd0 and no counter logic is built. The port is present in both cases.

Decomposition:
- Package seg7_pkg:
  - segment pattern constants for 0-9;
  - SEG_BLANK, BCD_BLANK = 4'hF;
  - SEG_DOT_BIT = 7;
  - typedef seg7_frame_t (4 x 4-bit BCD).
- Sub-module seg7_decode: combinational 7-bit pattern -> {valid, is_blank, bcd[3:0]}. It is shared with future encoder checks.

Test Plan:
- Scan 1,2,3,4 one-hot (8'b0000_0110 on digits 4'b1000, etc., 16 cycles each), STABLE_FRAMES=2 -> o_Frame_Valid pulses once after the second full scan, o_Frame=16'h1234, o_Dots=0.
- Single accept of i_Digits=4'b1111, i_Segments=8'b1011_1111, repeated -> o_Frame=16'h0000, o_Dots=4'b1111 after 2 dwells.
- Digit-1 dwell of 2 cycles (< SETTLE_CYCLES=4) carrying pattern 7 inside a valid 12:34 scan -> no change, no error, frame stays 16'h1234.
- Pattern 7'b1010101 on digit 0 -> o_Pattern_Err one pulse, no Frame_Valid; with SEG_CAPTURE_ERR_COUNT_EN, o_Err_Count=1, and 300 errors -> 255.
- i_Digits=0 for 1024 cycles -> o_Blank=1 at cycle 1024+1, cleared the cycle after digits resume; the next 12:34 scan requires 2 full frames again.
- Reset asserted after 2 of 4 digits -> outputs return to reset values; the next 2 scans of 56:78 give 16'h5678 with no stale digits.
